// File: rtl/shift_right_sequential_if.sv
// rtl/shift_right_sequential_if.sv - request/result handshake bundle for the sequential right shifter
interface shift_right_sequential_if #(
  parameter int N = 32
);
  localparam int S = $clog2(N);

  // Request side: operand, shift amount and mode, qualified by in_valid/in_ready
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in;
  logic [S-1:0] shamt;
  logic         arith;

  // Result side: out is held stable while out_valid is high
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out;

  // High while an operation is in flight or its result is waiting
  logic         busy;

  // Producer of requests and consumer of results
  modport master (
    output in_valid, in, shamt, arith, out_ready,
    input  in_ready, out_valid, out, busy
  );

  // The shifter itself
  modport slave (
    input  in_valid, in, shamt, arith, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/shift_right_sequential.sv
// rtl/shift_right_sequential.sv - iterative log-stage logical/arithmetic right shifter
module shift_right_sequential #(
  parameter int N = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  shift_right_sequential_if.slave bus
);
  localparam int S  = $clog2(N);
  // Stage counter runs 0..S; the extra value S marks "all stages applied"
  localparam int KW = $clog2(S + 1);
  localparam logic [KW-1:0] K_LAST = KW'(S);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [N-1:0]  acc_q;
  logic [N-1:0]  acc_d;
  logic [N-1:0]  out_q;
  logic [S-1:0]  sh_q;
  logic          fill_q;
  logic [KW-1:0] k_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          busy_q;

  // Single stage of the barrel: shift by 2^k when bit k of the latched amount is set
  always_comb begin
    acc_d = acc_q;
    for (int j = 0; j < S; j++) begin
      if (k_q == KW'(j) && sh_q[j]) begin
        acc_d = (acc_q >> (2 ** j)) | (fill_q ? ~({N{1'b1}} >> (2 ** j)) : '0);
      end
    end
  end

  // Control FSM with registered handshake outputs; fill is resolved once at accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      out_q       <= '0;
      sh_q        <= '0;
      fill_q      <= 1'b0;
      k_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            acc_q      <= bus.in;
            sh_q       <= bus.shamt;
            fill_q     <= bus.arith & bus.in[N-1];
            k_q        <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (k_q == K_LAST) begin
            out_q       <= acc_q;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            acc_q <= acc_d;
            k_q   <= k_q + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            k_q         <= '0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_shift_right_sequential.sv
// tb/tb_shift_right_sequential.sv - directed and randomized bench for shift_right_sequential
module tb_shift_right_sequential;
  localparam int N = 32;
  localparam int S = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks   = 0;
  int passes   = 0;
  int fails    = 0;
  int hs_count = 0;
  int ops_done = 0;

  always #5 clk = ~clk;

  shift_right_sequential_if #(.N(N)) bus ();

  shift_right_sequential #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Count result handshakes to detect lost or duplicated results
  always @(posedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) hs_count++;
  end

  function automatic logic [N-1:0] model(input logic [N-1:0] a, input int s, input logic ar);
    logic signed [N-1:0] sa;
    sa = a;
    if (ar) return sa >>> s;
    return a >> s;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction: request, wait for result, optional stall, consume
  task automatic run_op(input logic [N-1:0] a, input int s, input logic ar, input logic [N-1:0] exp,
                        input int stall, input bit rnd_ready, input bit pulse_in);
    int n;
    int lat;
    bit ok;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in       = a;
    bus.shamt    = s[S-1:0];
    bus.arith    = ar;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in       = $urandom;
    bus.shamt    = S'($urandom);
    bus.arith    = 1'($urandom);
    check("busy_after_accept", {bus.busy, bus.in_ready}, 2'b10);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      if (rnd_ready) bus.out_ready = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    bus.out_ready = 1'b0;
    check("latency", lat, S + 1);
    check("result", bus.out, exp);
    ok = 1'b1;
    for (int i = 0; i < stall; i++) begin
      if (pulse_in) begin
        bus.in_valid = 1'($urandom);
        bus.in       = $urandom;
        bus.shamt    = S'($urandom);
      end
      @(posedge clk); #1;
      if (!(bus.out_valid === 1'b1 && bus.out === exp && bus.in_ready === 1'b0 && bus.busy === 1'b1))
        ok = 1'b0;
    end
    bus.in_valid = 1'b0;
    if (stall > 0) check("backpressure_hold", ok, 1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    ops_done++;
    check("idle_after_consume", {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
  endtask

  initial begin
    logic [N-1:0] a;
    int s;
    logic ar;
    bit ok;
    bus.in_valid  = 1'b0;
    bus.in        = '0;
    bus.shamt     = '0;
    bus.arith     = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out", bus.out, 0);
    check("reset_busy", bus.busy, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a shift discards the operation
    bus.in_valid = 1'b1;
    bus.in       = 32'h8000_00F0;
    bus.shamt    = 5'd4;
    bus.arith    = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("busy_mid_shift", bus.busy, 1);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out", bus.out, 0);
    check("midrst_busy", bus.busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    ok = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) ok = 1'b0;
    end
    bus.out_ready = 1'b0;
    check("no_pulse_after_reset", ok, 1);
    check("handshakes_after_reset", hs_count, 0);

    // Directed cases
    run_op(32'h8000_00F0, 4,  1'b0, 32'h0800_000F, 0, 0, 0);
    run_op(32'h8000_00F0, 4,  1'b1, 32'hF800_000F, 0, 0, 0);
    run_op(32'h8000_00F0, 31, 1'b1, 32'hFFFF_FFFF, 0, 0, 0);
    run_op(32'hDEAD_BEEF, 0,  1'b0, 32'hDEAD_BEEF, 0, 0, 0);
    run_op(32'hDEAD_BEEF, 0,  1'b1, 32'hDEAD_BEEF, 0, 0, 0);
    run_op(32'h8000_0000, 31, 1'b0, 32'h0000_0001, 0, 0, 0);
    run_op(32'h7FFF_FFFF, 31, 1'b1, 32'h0000_0000, 0, 0, 0);
    run_op(32'h7000_0000, 3,  1'b1, 32'h0E00_0000, 0, 0, 0);
    run_op(32'hC35A_0F0F, 17, 1'b1, 32'hFFFF_E1AD, 10, 0, 1);

    // Randomized operands, modes and stalls against the arithmetic model
    for (int t = 0; t < 3000; t++) begin
      a  = $urandom;
      s  = $urandom_range(0, N - 1);
      ar = 1'($urandom_range(0, 1));
      run_op(a, s, ar, model(a, s, ar), $urandom_range(0, 3), 1, 1);
    end

    check("handshake_count", hs_count, ops_done);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
